// File: rtl/regfile_mp.sv
// regfile_mp: parameterised multi-read, dual-write register file.
// Write port 1 wins on same-address writes; optional hardwired zero
// register and same-cycle write-to-read forwarding.

// Single read lane: stored value, optionally overridden by an in-flight write.
module regfile_mp_rdport #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic [DEPTH-1:0][WIDTH-1:0] i_mem,
  input  logic                        i_reset,
  input  logic [AW-1:0]               i_raddr,
  input  logic                        i_we0,
  input  logic [AW-1:0]               i_waddr0,
  input  logic [WIDTH-1:0]            i_wdata0,
  input  logic                        i_we1,
  input  logic [AW-1:0]               i_waddr1,
  input  logic [WIDTH-1:0]            i_wdata1,
  output logic [WIDTH-1:0]            o_rdata
);
  // Forward port 1 ahead of port 0 so the read matches what the edge stores;
  // a pending reset suppresses forwarding, and r0 is forced to zero last.
  always_comb begin
    o_rdata = i_mem[i_raddr];
    if ((BYPASS != 0) && !i_reset) begin
      if (i_we1 && (i_waddr1 == i_raddr))      o_rdata = i_wdata1;
      else if (i_we0 && (i_waddr0 == i_raddr)) o_rdata = i_wdata0;
    end
    if ((ZERO_REG != 0) && (i_raddr == '0)) o_rdata = '0;
  end
endmodule

module regfile_mp #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int NREAD    = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREAD*AW-1:0]    raddr,
  output logic [NREAD*WIDTH-1:0] rdata,
  input  logic                   we0,
  input  logic [AW-1:0]          waddr0,
  input  logic [WIDTH-1:0]       wdata0,
  input  logic                   we1,
  input  logic [AW-1:0]          waddr1,
  input  logic [WIDTH-1:0]       wdata1,
  output logic                   wcollide
);
  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic                        r_wcollide;
  logic                        w_we0, w_we1, w_collide;

  // Effective enables: a write to the hardwired zero register is a no-op,
  // so it neither updates storage, forwards, nor counts as a collision.
  always_comb begin
    w_we0     = we0 && !((ZERO_REG != 0) && (waddr0 == '0));
    w_we1     = we1 && !((ZERO_REG != 0) && (waddr1 == '0));
    w_collide = w_we0 && w_we1 && (waddr0 == waddr1);
  end

  // Storage and collision flag; port 1 is written last so it wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem      <= '0;
      r_wcollide <= 1'b0;
    end else begin
      if (w_we0) r_mem[waddr0] <= wdata0;
      if (w_we1) r_mem[waddr1] <= wdata1;
      r_wcollide <= w_collide;
    end
  end

  assign wcollide = r_wcollide;

  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    regfile_mp_rdport #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
    ) u_rd (
      .i_mem   (r_mem),
      .i_reset (reset),
      .i_raddr (raddr[g*AW +: AW]),
      .i_we0   (w_we0),
      .i_waddr0(waddr0),
      .i_wdata0(wdata0),
      .i_we1   (w_we1),
      .i_waddr1(waddr1),
      .i_wdata1(wdata1),
      .o_rdata (rdata[g*WIDTH +: WIDTH])
    );
  end
endmodule
